count_disp_scan: RTL and testbench
==================================

COUNT_DISP_SCAN -- requirements
Module: count_disp_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter BLANK_CYC, default 2000, giving the all-anodes-off cycles at the start of each slot (anti-ghosting); legal range is 0 to REFRESH_DIV-1.
REQ-003 Port clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port count  input  4  SHALL be the binary counter value to display, generated in an unrelated clock domain and treated as asynchronous.
REQ-006 Port seg  output  7  SHALL carry the segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 Port an  output  4  SHALL carry the digit anodes, active-low, with an[0] as the rightmost digit.
REQ-008 Port dp  output  1  SHALL carry the decimal point, active-low, and SHALL be held at 1 (off) at all times.

Function
REQ-009 count SHALL pass through a two-flop synchronizer before any other use.
REQ-010 A slot counter SHALL run from 0 to REFRESH_DIV-1 and then wrap to 0; digit index idx (0..3) SHALL advance by 1 on each slot wrap, with idx 3 wrapping to 0.
REQ-011 When slot=0 and idx=0 (frame start), the synchronized count SHALL be captured into snap[3:0]; snap SHALL NOT change at any other time, so a count change mid-frame has no effect until the next frame.
REQ-012 From snap the block SHALL derive ones = snap mod 10 and tens = snap / 10 (tens is 0 or 1, since snap is at most 15).
REQ-013 Digit map: idx 0 SHALL show ones, idx 1 SHALL show tens, and idx 2 and idx 3 SHALL be blank digits.
REQ-014 Scan states per slot: BLANK while slot < BLANK_CYC, giving an=4'b1111 and seg=7'b1111111; DRIVE otherwise.
REQ-015 In DRIVE, a non-blank digit SHALL drive only the anode bit an[idx] low and put the digit's pattern on seg; a blank digit SHALL drive an=4'b1111 and seg=7'b1111111.
REQ-016 seg, an and dp SHALL be registered, each reflecting the (slot, idx, snap) values of the preceding cycle (1-cycle latency).
REQ-017 Segment patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 At no time SHALL more than one bit of an be low.
REQ-019 With BLANK_CYC=0, the BLANK state SHALL never occur and each digit SHALL be driven for the full slot.

Reset
REQ-020 On rst=0, slot, idx, snap and both synchronizer flops SHALL clear to 0 immediately, independent of clk.
REQ-021 On rst=0, outputs SHALL be forced immediately to an=4'b1111, seg=7'b1111111 and dp=1.
REQ-022 After rst is released, the first rising clk edge SHALL be treated as frame start with slot=0 and idx=0; a reset asserted mid-slot SHALL abandon that slot with no partial output.

Configuration
REQ-023 With macro LEAD_ZERO_BLANK_EN defined, idx 1 SHALL be displayed as a blank digit when tens=0.
REQ-024 Without LEAD_ZERO_BLANK_EN, idx 1 SHALL always show tens, including the "0" pattern.

Verification
REQ-025 Bench parameters SHALL be REFRESH_DIV=8 and BLANK_CYC=2 (32-cycle frame).
REQ-026 Scenario: count=4'd12 held, rst released -> idx 0 DRIVE gives an=1110, seg=0100100; idx 1 DRIVE gives an=1101, seg=1111001; idx 2 and idx 3 give an=1111.
REQ-027 Scenario: count=4'd7 -> idx 1 shows seg=1000000 and an=1101 without the macro, and an=1111 with LEAD_ZERO_BLANK_EN.
REQ-028 Scenario: count changes 3 to 15 at frame cycle 10 -> the remainder of that frame still shows 3; the next frame shows ones=5 (0010010) and tens=1.
REQ-029 Scenario: every slot -> exactly 2 cycles of an=1111 followed by 6 cycles of the driven digit; an is checked to be one-hot-low or all-high on every cycle.
REQ-030 Scenario: rst pulsed low at cycle 13, between clk edges -> outputs go to an=1111, seg=1111111 within the same cycle; after release, the scan restarts at idx 0 and the counts repeat.
REQ-031 Scenario: count swept 0 to 15, one value per frame -> the displayed tens/ones pair matches the decimal value of count, lagging it by exactly one frame.

Source files
------------

// File: rtl/count_disp_scan.sv
// Scans a 4-bit count as two decimal digits onto a 4-digit active-low 7-segment display.
// Optional macro LEAD_ZERO_BLANK_EN blanks the tens digit when it is zero.
module count_disp_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYC);

  typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  scan_state_t   scan_state;
  logic [3:0]    ones;
  logic          tens;
  logic [3:0]    digit_val;
  logic          digit_blank;
  logic [6:0]    digit_seg;

  // With no blanking window the compare would be against zero, so drop it entirely.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign scan_state = S_DRIVE;
    end else begin : g_blank
      assign scan_state = (slot_q < BLANK_LIM) ? S_BLANK : S_DRIVE;
    end
  endgenerate

  always_comb begin
    sync1_d = count;
    sync2_d = sync1_q;
    slot_d  = slot_q + 1'b1;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (slot_q == SLOT_MAX) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    // Capture only at frame start so one frame never mixes two count values.
    if ((slot_q == '0) && (idx_q == 2'd0)) begin
      snap_d = sync2_q;
    end
  end

  always_comb begin
    ones        = (snap_q >= 4'd10) ? (snap_q - 4'd10) : snap_q;
    tens        = (snap_q >= 4'd10);
    digit_val   = 4'd0;
    digit_blank = 1'b1;
    case (idx_q)
      2'd0: begin
        digit_val   = ones;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_val   = {3'b000, tens};
`ifdef LEAD_ZERO_BLANK_EN
        digit_blank = ~tens;
`else
        digit_blank = 1'b0;
`endif
      end
      default: begin
        digit_val   = 4'd0;
        digit_blank = 1'b1;
      end
    endcase

    case (digit_val)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = 7'b1111111;
    endcase

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if ((scan_state == S_DRIVE) && !digit_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_count_disp_scan.sv
// Directed bench for count_disp_scan with REFRESH_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_count_disp_scan;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  logic [6:0] seg_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  count_disp_scan #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " an"}, {28'd0, an}, 32'hf);
    check_eq({tag, " seg"}, {25'd0, seg}, 32'h7f);
    check_eq({tag, " dp"}, {31'd0, dp}, 32'd1);
  endtask

  // Steps through a frame, checking each cycle against the expected digits.
  // Cycle i after frame start reflects slot i%8 and idx i/8 of the previous cycle.
  task automatic run_frame(input int ones, input int tens, input int n_steps,
                           input int chg_step, input logic [3:0] chg_val);
    int slot;
    int idx;
    logic tens_blank;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    string tag;
`ifdef LEAD_ZERO_BLANK_EN
    tens_blank = (tens == 0);
`else
    tens_blank = 1'b0;
`endif
    for (int i = 0; i < n_steps; i++) begin
      @(posedge clk);
      #1;
      slot    = i % 8;
      idx     = i / 8;
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      if (slot >= 2) begin
        if (idx == 0) begin
          exp_an  = 4'b1110;
          exp_seg = seg_pat[ones];
        end else if (idx == 1 && !tens_blank) begin
          exp_an  = 4'b1101;
          exp_seg = seg_pat[tens];
        end
      end
      tag = $sformatf("frame%0d cyc%0d", frame_no, i);
      $display("%s: count=%0d an=%b seg=%b dp=%b", tag, count, an, seg, dp);
      check_eq({tag, " an"}, {28'd0, an}, {28'd0, exp_an});
      check_eq({tag, " seg"}, {25'd0, seg}, {25'd0, exp_seg});
      check_eq({tag, " dp"}, {31'd0, dp}, 32'd1);
      check_eq({tag, " an_onehot"}, {31'd0, ($countones(~an) <= 1)}, 32'd1);
      if (i == chg_step) count = chg_val;
    end
    frame_no++;
  endtask

  initial begin
    rst   = 1'b1;
    count = 4'd12;
    #2;
    rst = 1'b0;
    #1;
    check_dark("reset_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset_held");
    @(negedge clk);
    rst = 1'b1;

    // First frame shows the cleared snapshot; count appears one frame later.
    run_frame(0, 0, 32, -1, 4'd0);
    run_frame(2, 1, 32, 16, 4'd7);
    run_frame(7, 0, 32, 16, 4'd3);
    run_frame(3, 0, 32, 10, 4'd15);
    run_frame(5, 1, 32, 16, 4'd0);

    for (int v = 0; v < 16; v++) begin
      run_frame(v % 10, v / 10, 32, 16, (v == 15) ? 4'd12 : 4'(v + 1));
    end

    // Reset mid-slot while the tens digit is being driven.
    run_frame(2, 1, 14, -1, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    check_dark("midslot_reset_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_dark("midslot_reset_held");
    @(negedge clk);
    rst = 1'b1;
    run_frame(0, 0, 32, -1, 4'd0);
    run_frame(2, 1, 32, -1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
